// File: rtl/l1_mmu_responder.sv
// Memory-side responder for the L1-to-MMU line interface: 8-beat line bursts to a word RAM,
// single-word MMIO accesses with a timeout, and one-cycle done pulses followed by a GAP cycle.
module l1_mmu_responder #(
    parameter int          MEM_AW       = 14,
    parameter logic [15:0] MMIO_HI      = 16'hFFFF,
    parameter int          MMIO_TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              l1_mmu_req_read,
    input  logic              l1_mmu_req_write,
    input  logic [31:0]       l1_mmu_req_addr,
    input  logic [255:0]      l1_mmu_write_data,
    output logic              mmu_l1_read_done,
    output logic              mmu_l1_write_done,
    output logic [255:0]      mmu_l1_read_data,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              mmio_req,
    output logic              mmio_we,
    output logic [31:0]       mmio_addr,
    output logic [31:0]       mmio_wdata,
    input  logic [31:0]       mmio_rdata,
    input  logic              mmio_ready
);

    typedef enum logic [2:0] {IDLE, MEM_RD, MEM_WR, MMIO, DONE, GAP} state_t;

    // Counter starts at 1 on accept, so DONE lands MMIO_TIMEOUT cycles after the accept cycle.
    localparam logic [7:0] TO_CNT = 8'(MMIO_TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [3:0]     beat_q, beat_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           op_we_q, op_we_d;
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   wdata_q, wdata_d;
    logic [255:0]   rdata_q, rdata_d;
    logic [2:0]     cap_idx;
    logic [MEM_AW-1:0] line_addr;

    // Beat count is 3 bits wide in the address: no carry into the line base.
    assign line_addr = {addr_q[MEM_AW+1:5], beat_q[2:0]};
    assign cap_idx   = beat_q[2:0] - 3'd1;

    assign mmu_l1_read_data = rdata_q;

    always_comb begin
        state_d           = state_q;
        beat_d            = beat_q;
        cnt_d             = cnt_q;
        op_we_d           = op_we_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        rdata_d           = rdata_q;
        mmu_l1_read_done  = 1'b0;
        mmu_l1_write_done = 1'b0;
        mem_addr          = '0;
        mem_we            = 1'b0;
        mem_wdata         = '0;
        mmio_req          = 1'b0;
        mmio_we           = 1'b0;
        mmio_addr         = '0;
        mmio_wdata        = '0;

        case (state_q)
            IDLE: begin
                if (l1_mmu_req_read || l1_mmu_req_write) begin
                    op_we_d = l1_mmu_req_write;
                    addr_d  = l1_mmu_req_addr;
                    wdata_d = l1_mmu_write_data;
                    beat_d  = '0;
                    cnt_d   = 8'd1;
                    if (l1_mmu_req_addr[31:16] == MMIO_HI) state_d = MMIO;
                    else if (l1_mmu_req_write)             state_d = MEM_WR;
                    else                                   state_d = MEM_RD;
                end
            end
            MEM_WR: begin
                mem_we    = 1'b1;
                mem_addr  = line_addr;
                mem_wdata = wdata_q[{beat_q[2:0], 5'b0} +: 32];
                if (beat_q[2:0] == 3'd7) state_d = DONE;
                else                     beat_d  = beat_q + 4'd1;
            end
            MEM_RD: begin
                mem_addr = line_addr;
                // RAM data lags the address by one cycle; beat 8 is the extra capture for word 7.
                if (beat_q != 4'd0) rdata_d[{cap_idx, 5'b0} +: 32] = mem_rdata;
                if (beat_q == 4'd8) state_d = DONE;
                else                beat_d  = beat_q + 4'd1;
            end
            MMIO: begin
                mmio_req   = 1'b1;
                mmio_we    = op_we_q;
                mmio_addr  = addr_q;
                mmio_wdata = wdata_q[31:0];
                if (mmio_ready) begin
                    if (!op_we_q) rdata_d = {224'b0, mmio_rdata};
                    state_d = DONE;
                end else if (cnt_q == TO_CNT) begin
                    if (!op_we_q) rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                mmu_l1_read_done  = !op_we_q;
                mmu_l1_write_done = op_we_q;
                state_d           = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cnt_q   <= '0;
            op_we_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            op_we_q <= op_we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
